cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_if.sv | 29 ++
 rtl/cpu_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer_if
// Description : Instruction-ROM fetch bus between the sequencer and its ROM.
// Revision    : 1.0
// ============================================================================
interface cpu_sequencer_if #(
    parameter int PC_W = 8
) ();
    logic            rom_req;
    logic [PC_W-1:0] rom_addr;
    logic            rom_ack;
    logic [7:0]      rom_data;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_data
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_data
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Two-byte instruction fetch/decode/execute control sequencer.
// Revision    : 1.0
// ============================================================================
module cpu_sequencer #(
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              run,
    cpu_sequencer_if.master        rom,
    output logic                   rd_en_a,
    output logic                   rd_en_b,
    output logic [2:0]             rd_addr_a,
    output logic [2:0]             rd_addr_b,
    output logic [7:0]             imm,
    output logic                   mul_sel,
    output logic                   alu_en,
    output logic [2:0]             fs,
    output logic                   wr_en,
    output logic [2:0]             wr_addr,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [2:0] c_OP_JUMP = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_FETCH_LO = 3'd2,
        S_DECODE   = 3'd3,
        S_READ     = 3'd4,
        S_EXEC     = 3'd5,
        S_WRITE    = 3'd6,
        S_HALT     = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir_hi;
    logic [7:0]      r_ir_lo;
    logic            w_rom_req;
    logic            w_ack;

    logic [2:0]      w_opcode;
    logic            w_operand_num;
    logic            w_op2_type;
    logic [2:0]      w_op1_addr;
    logic            w_use_reg_b;
    logic [PC_W-1:0] w_jump_target;

    assign w_opcode      = r_ir_hi[7:5];
    assign w_operand_num = r_ir_hi[4];
    assign w_op2_type    = r_ir_hi[3];
    assign w_op1_addr    = r_ir_hi[2:0];
    // Second register port is only needed for a two-operand register-register op.
    assign w_use_reg_b   = w_operand_num & ~w_op2_type;
    assign w_jump_target = PC_W'(r_ir_lo);

    // An ack without a live request is meaningless and must not advance fetch.
    assign w_ack        = w_rom_req & rom.rom_ack;
    assign rom.rom_req  = w_rom_req;
    assign rom.rom_addr = r_pc;

    assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted = (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= PC_W'(RESET_PC);
            r_ir_hi <= 8'h00;
            r_ir_lo <= 8'h00;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_FETCH_HI: begin
                    if (w_ack) begin
                        r_ir_hi <= rom.rom_data;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                S_FETCH_LO: begin
                    if (w_ack) begin
                        r_ir_lo <= rom.rom_data;
                        r_pc    <= r_pc + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_opcode == c_OP_JUMP) begin
                        r_pc <= w_jump_target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rom_req    = 1'b0;
        rd_en_a      = 1'b0;
        rd_en_b      = 1'b0;
        rd_addr_a    = 3'd0;
        rd_addr_b    = 3'd0;
        imm          = 8'h00;
        mul_sel      = 1'b0;
        alu_en       = 1'b0;
        fs           = 3'd0;
        wr_en        = 1'b0;
        wr_addr      = 3'd0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH_HI;
                end
            end
            S_FETCH_HI: begin
                w_rom_req = 1'b1;
                if (rom.rom_ack) begin
                    w_state_next = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                w_rom_req = 1'b1;
                if (rom.rom_ack) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_opcode == c_OP_HALT) begin
                    w_state_next = S_HALT;
                end else if (w_opcode == c_OP_JUMP) begin
                    w_state_next = run ? S_FETCH_HI : S_IDLE;
                end else begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                rd_en_a      = 1'b1;
                rd_en_b      = w_use_reg_b;
                rd_addr_a    = w_op1_addr;
                rd_addr_b    = r_ir_lo[2:0];
                mul_sel      = w_op2_type;
                imm          = r_ir_lo;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                rd_en_a      = 1'b1;
                rd_en_b      = w_use_reg_b;
                rd_addr_a    = w_op1_addr;
                rd_addr_b    = r_ir_lo[2:0];
                mul_sel      = w_op2_type;
                imm          = r_ir_lo;
                alu_en       = 1'b1;
                fs           = w_opcode;
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                mul_sel      = w_op2_type;
                imm          = r_ir_lo;
                wr_en        = 1'b1;
                wr_addr      = w_op1_addr;
                w_state_next = run ? S_FETCH_HI : S_IDLE;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
